// File: rtl/train_scheduler.sv
// Training/inference sequencer: gates sample tokens into batches and epochs and raises weight-update requests.
// Optional build macro LR_DECAY_EN: halve the learning rate at each epoch end, floored at LR_MIN.
module train_scheduler #(
    parameter int WD     = 4,
    parameter int BATCH  = 8,
    parameter int NBATCH = 4,
    parameter int WE     = 8,
    parameter int LR_MIN = 1
) (
    input  logic          iCLK,
    input  logic          iRST,
    input  logic          iStart,
    input  logic          iTrain,
    input  logic [WE-1:0] iEpochs,
    input  logic [WD-1:0] iLR0,
    input  logic          iValid_AS,
    output logic          oReady_AS,
    output logic          oValid_BS,
    input  logic          iReady_BS,
    output logic          oValid_UP,
    input  logic          iReady_UP,
    output logic          oMode,
    output logic [WD-1:0] oLR,
    output logic [WE-1:0] oEpoch,
    output logic          oBusy,
    output logic          oDone
);
    localparam int SW = (BATCH > 1) ? $clog2(BATCH) : 1;
    localparam int BW = (NBATCH > 1) ? $clog2(NBATCH) : 1;
    localparam logic [SW-1:0] SAMPLE_LAST = SW'(BATCH - 1);
    localparam logic [BW-1:0] BATCH_LAST  = BW'(NBATCH - 1);

    typedef enum logic [1:0] {IDLE, RUN, UPDATE, DONE} stateT;

    stateT          stateReg;
    stateT          stateNext;
    logic           modeReg;
    logic [WE-1:0]  epochsReg;
    logic [WE-1:0]  epochCntReg;
    logic [WE-1:0]  epochInc;
    logic [WD-1:0]  lrReg;
    logic [WD-1:0]  lrNext;
    logic [SW-1:0]  sampleCntReg;
    logic [BW-1:0]  batchCntReg;
    logic           xfer;
    logic           batchEnd;
    logic           batchAdvance;
    logic           epochEnd;
    logic           lastEpoch;

    // In training the batch only counts once its update request is accepted.
    assign xfer         = (stateReg == RUN) && iValid_AS && iReady_BS;
    assign batchEnd     = xfer && (sampleCntReg == SAMPLE_LAST);
    assign batchAdvance = modeReg ? ((stateReg == UPDATE) && iReady_UP) : batchEnd;
    assign epochEnd     = batchAdvance && (batchCntReg == BATCH_LAST);
    assign epochInc     = epochCntReg + 1'b1;
    assign lastEpoch    = epochEnd && (epochInc == epochsReg);

`ifdef LR_DECAY_EN
    localparam logic [WD-1:0] LR_FLOOR = WD'(LR_MIN);

    // A rate already under the floor is left alone rather than raised.
    always_comb begin
        lrNext = lrReg;
        if (lrReg >= LR_FLOOR) begin
            lrNext = ((lrReg >> 1) < LR_FLOOR) ? LR_FLOOR : (lrReg >> 1);
        end
    end
`else
    assign lrNext = lrReg;
`endif

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            stateReg <= IDLE;
        end else begin
            stateReg <= stateNext;
        end
    end

    always_comb begin
        stateNext = stateReg;
        case (stateReg)
            IDLE: begin
                if (iStart) begin
                    stateNext = (iEpochs == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (batchEnd) begin
                    if (modeReg) begin
                        stateNext = UPDATE;
                    end else if (lastEpoch) begin
                        stateNext = DONE;
                    end
                end
            end
            UPDATE: begin
                if (iReady_UP) begin
                    stateNext = lastEpoch ? DONE : RUN;
                end
            end
            DONE:    stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_comb begin
        oValid_BS = 1'b0;
        oReady_AS = 1'b0;
        oValid_UP = 1'b0;
        oBusy     = 1'b1;
        oDone     = 1'b0;
        case (stateReg)
            IDLE:   oBusy = 1'b0;
            RUN: begin
                oValid_BS = iValid_AS;
                oReady_AS = iReady_BS;
            end
            UPDATE: oValid_UP = 1'b1;
            DONE:   oDone = 1'b1;
            default: oBusy = 1'b0;
        endcase
    end

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            modeReg      <= 1'b0;
            epochsReg    <= '0;
            epochCntReg  <= '0;
            lrReg        <= '0;
            sampleCntReg <= '0;
            batchCntReg  <= '0;
        end else if ((stateReg == IDLE) && iStart) begin
            modeReg      <= iTrain;
            epochsReg    <= iEpochs;
            lrReg        <= iLR0;
            epochCntReg  <= '0;
            sampleCntReg <= '0;
            batchCntReg  <= '0;
        end else begin
            if (xfer) begin
                sampleCntReg <= (sampleCntReg == SAMPLE_LAST) ? '0 : sampleCntReg + 1'b1;
            end
            if (batchAdvance) begin
                batchCntReg <= (batchCntReg == BATCH_LAST) ? '0 : batchCntReg + 1'b1;
            end
            if (epochEnd) begin
                epochCntReg <= epochInc;
                lrReg       <= lrNext;
            end
        end
    end

    assign oMode  = modeReg;
    assign oLR    = lrReg;
    assign oEpoch = epochCntReg;

endmodule

// File: tb/tb_train_scheduler.sv
// Randomized self-checking bench for train_scheduler; expectations come from run-level arithmetic
// (transfers per batch/epoch, learning rate per epoch index) rather than cycle-level state.
module tb_train_scheduler;
    localparam int WD     = 4;
    localparam int BATCH  = 8;
    localparam int NBATCH = 4;
    localparam int WE     = 8;
    localparam int LR_MIN = 1;

    logic          iCLK = 1'b0;
    logic          iRST;
    logic          iStart;
    logic          iTrain;
    logic [WE-1:0] iEpochs;
    logic [WD-1:0] iLR0;
    logic          iValid_AS;
    logic          oReady_AS;
    logic          oValid_BS;
    logic          iReady_BS;
    logic          oValid_UP;
    logic          iReady_UP;
    logic          oMode;
    logic [WD-1:0] oLR;
    logic [WE-1:0] oEpoch;
    logic          oBusy;
    logic          oDone;

    train_scheduler #(
        .WD(WD), .BATCH(BATCH), .NBATCH(NBATCH), .WE(WE), .LR_MIN(LR_MIN)
    ) dut (
        .iCLK(iCLK), .iRST(iRST), .iStart(iStart), .iTrain(iTrain),
        .iEpochs(iEpochs), .iLR0(iLR0),
        .iValid_AS(iValid_AS), .oReady_AS(oReady_AS),
        .oValid_BS(oValid_BS), .iReady_BS(iReady_BS),
        .oValid_UP(oValid_UP), .iReady_UP(iReady_UP),
        .oMode(oMode), .oLR(oLR), .oEpoch(oEpoch), .oBusy(oBusy), .oDone(oDone)
    );

    always #5 iCLK = ~iCLK;

    int checks = 0;
    int errors = 0;

    // Observations gathered by the run driver for the test tasks to judge.
    int nXfer, nUp, doneCount, doneCycle, maxUpWait;
    int passErrs, lrErrs, epochErrs, upBatchErrs, upDropErrs, modeErrs;
    bit timedOut, startLeak;
    int finalEpoch, finalLR, postEpoch, postLR;
    logic postBusy, postDone;
    int lrSeen [8];

    // Learning rate in force during epoch k of a run started with lr0.
    function automatic int lr_model(input int lr0, input int k);
        int lr;
        lr = lr0;
        for (int i = 0; i < k; i++) begin
`ifdef LR_DECAY_EN
            if (lr >= LR_MIN) lr = ((lr >> 1) < LR_MIN) ? LR_MIN : (lr >> 1);
`endif
        end
        return lr;
    endfunction

    task automatic run_scenario(input logic mode, input int epochs, input int lr0,
                                input bit rnd, input int stall);
        int cycles, upWait, idx, xferSinceUp;
        bit holdUp;
        cycles = 0; upWait = 0; xferSinceUp = 0; holdUp = 0;
        nXfer = 0; nUp = 0; doneCount = 0; doneCycle = -1; maxUpWait = 0;
        passErrs = 0; lrErrs = 0; epochErrs = 0; upBatchErrs = 0; upDropErrs = 0; modeErrs = 0;
        timedOut = 0; finalEpoch = -1; finalLR = -1;
        for (int i = 0; i < 8; i++) lrSeen[i] = -1;
        @(posedge iCLK); #1;
        iStart = 1'b1; iTrain = mode; iEpochs = WE'(epochs); iLR0 = WD'(lr0);
        iValid_AS = 1'b1; iReady_BS = 1'b1; iReady_UP = 1'b0;
        @(negedge iCLK);
        startLeak = iValid_AS & oReady_AS;
        while (doneCount == 0 && !timedOut) begin
            @(posedge iCLK); #1;
            iStart    = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
            iTrain    = 1'($urandom);
            iEpochs   = WE'($urandom);
            iLR0      = WD'($urandom);
            iValid_AS = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            iReady_BS = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            iReady_UP = (upWait >= stall) && (rnd ? ($urandom_range(0, 1) == 1) : 1'b1);
            @(negedge iCLK);
            cycles++;
            if (oValid_UP) begin
                if (oValid_BS || oReady_AS) passErrs++;
                if (iReady_UP) begin
                    if (xferSinceUp != BATCH) upBatchErrs++;
                    nUp++; xferSinceUp = 0; upWait = 0;
                end else begin
                    upWait++;
                    if (upWait > maxUpWait) maxUpWait = upWait;
                end
                holdUp = !iReady_UP;
            end else begin
                if (holdUp) upDropErrs++;
                holdUp = 0;
                if (oBusy && !oDone) begin
                    if (oValid_BS !== iValid_AS || oReady_AS !== iReady_BS) passErrs++;
                end else if (oValid_BS || oReady_AS) begin
                    passErrs++;
                end
            end
            if (oBusy && oMode !== mode) modeErrs++;
            if (iValid_AS && oReady_AS) begin
                idx = nXfer / (BATCH * NBATCH);
                if (int'(oLR) != lr_model(lr0, idx)) lrErrs++;
                if (int'(oEpoch) != idx) epochErrs++;
                if (idx < 8 && lrSeen[idx] < 0) lrSeen[idx] = int'(oLR);
                nXfer++; xferSinceUp++;
            end
            if (oDone) begin
                doneCount++; doneCycle = cycles;
                finalEpoch = int'(oEpoch); finalLR = int'(oLR);
            end
            if (cycles >= 6000) timedOut = 1;
        end
        iStart = 1'b0; iValid_AS = 1'b0;
        @(negedge iCLK);
        postBusy = oBusy; postDone = oDone; postEpoch = int'(oEpoch); postLR = int'(oLR);
        $display("run mode=%0d epochs=%0d lr0=%0d stall=%0d: xfers=%0d updates=%0d done@%0d epoch=%0d lr=%0d",
                 mode, epochs, lr0, stall, nXfer, nUp, doneCycle, finalEpoch, finalLR);
    endtask

    task automatic test_reset();
        iRST = 1'b1; iStart = 1'b0; iTrain = 1'b1; iEpochs = 8'd3; iLR0 = 4'd9;
        iValid_AS = 1'b1; iReady_BS = 1'b1; iReady_UP = 1'b1;
        repeat (2) @(negedge iCLK);
        checks++; if (oMode !== 1'b0)     begin errors++; $display("FAIL reset_mode got %0b want 0", oMode); end
        checks++; if (oLR !== '0)         begin errors++; $display("FAIL reset_lr got %0d want 0", oLR); end
        checks++; if (oEpoch !== '0)      begin errors++; $display("FAIL reset_epoch got %0d want 0", oEpoch); end
        checks++; if (oBusy !== 1'b0)     begin errors++; $display("FAIL reset_busy got %0b want 0", oBusy); end
        checks++; if (oDone !== 1'b0)     begin errors++; $display("FAIL reset_done got %0b want 0", oDone); end
        checks++; if (oValid_UP !== 1'b0) begin errors++; $display("FAIL reset_valid_up got %0b want 0", oValid_UP); end
        checks++; if (oValid_BS !== 1'b0) begin errors++; $display("FAIL reset_valid_bs got %0b want 0", oValid_BS); end
        checks++; if (oReady_AS !== 1'b0) begin errors++; $display("FAIL reset_ready_as got %0b want 0", oReady_AS); end
        iRST = 1'b0; iValid_AS = 1'b0;
        $display("reset: outputs checked");
    endtask

    task automatic test_train_basic();
        run_scenario(1'b1, 1, 8, 1'b0, 0);
        checks++; if (timedOut)           begin errors++; $display("FAIL train_timeout got 1 want 0"); end
        checks++; if (nXfer != 32)        begin errors++; $display("FAIL train_xfers got %0d want 32", nXfer); end
        checks++; if (nUp != 4)           begin errors++; $display("FAIL train_updates got %0d want 4", nUp); end
        checks++; if (doneCount != 1)     begin errors++; $display("FAIL train_done_count got %0d want 1", doneCount); end
        checks++; if (finalEpoch != 1)    begin errors++; $display("FAIL train_epoch got %0d want 1", finalEpoch); end
        checks++; if (finalLR != lr_model(8, 1)) begin errors++; $display("FAIL train_lr got %0d want %0d", finalLR, lr_model(8, 1)); end
        checks++; if (upBatchErrs != 0)   begin errors++; $display("FAIL train_update_spacing got %0d bad want 0", upBatchErrs); end
        checks++; if (passErrs != 0)      begin errors++; $display("FAIL train_passthrough got %0d bad want 0", passErrs); end
        checks++; if (lrErrs + epochErrs + modeErrs != 0) begin errors++; $display("FAIL train_status got %0d bad want 0", lrErrs + epochErrs + modeErrs); end
        checks++; if (startLeak)          begin errors++; $display("FAIL train_start_transfer got 1 want 0"); end
        checks++; if (postBusy !== 1'b0 || postDone !== 1'b0) begin errors++; $display("FAIL train_after_done busy=%0b done=%0b want 0 0", postBusy, postDone); end
        checks++; if (postEpoch != 1 || postLR != finalLR) begin errors++; $display("FAIL train_hold epoch=%0d lr=%0d want 1 %0d", postEpoch, postLR, finalLR); end
    endtask

    task automatic test_inference();
        int lr0;
        lr0 = $urandom_range(0, 15);
        run_scenario(1'b0, 2, lr0, 1'b0, 0);
        checks++; if (timedOut)           begin errors++; $display("FAIL infer_timeout got 1 want 0"); end
        checks++; if (nXfer != 64)        begin errors++; $display("FAIL infer_xfers got %0d want 64", nXfer); end
        checks++; if (nUp != 0)           begin errors++; $display("FAIL infer_updates got %0d want 0", nUp); end
        checks++; if (doneCount != 1)     begin errors++; $display("FAIL infer_done_count got %0d want 1", doneCount); end
        checks++; if (finalEpoch != 2)    begin errors++; $display("FAIL infer_epoch got %0d want 2", finalEpoch); end
        checks++; if (finalLR != lr_model(lr0, 2)) begin errors++; $display("FAIL infer_lr got %0d want %0d", finalLR, lr_model(lr0, 2)); end
        checks++; if (passErrs + lrErrs + epochErrs + modeErrs != 0) begin errors++; $display("FAIL infer_status got %0d bad want 0", passErrs + lrErrs + epochErrs + modeErrs); end
    endtask

    task automatic test_update_stall();
        run_scenario(1'b1, 1, 8, 1'b0, 5);
        checks++; if (timedOut)           begin errors++; $display("FAIL stall_timeout got 1 want 0"); end
        checks++; if (maxUpWait != 5)     begin errors++; $display("FAIL stall_wait got %0d want 5", maxUpWait); end
        checks++; if (upDropErrs != 0)    begin errors++; $display("FAIL stall_valid_drop got %0d want 0", upDropErrs); end
        checks++; if (passErrs != 0)      begin errors++; $display("FAIL stall_ready_as got %0d bad want 0", passErrs); end
        checks++; if (upBatchErrs != 0)   begin errors++; $display("FAIL stall_sample_count got %0d bad want 0", upBatchErrs); end
        checks++; if (nXfer != 32 || nUp != 4) begin errors++; $display("FAIL stall_totals got %0d/%0d want 32/4", nXfer, nUp); end
    endtask

    task automatic test_lr_decay();
        int expLr [5];
`ifdef LR_DECAY_EN
        expLr = '{8, 4, 2, 1, 1};
`else
        expLr = '{8, 8, 8, 8, 8};
`endif
        run_scenario(1'b1, 5, 8, 1'b0, 0);
        for (int e = 0; e < 5; e++) begin
            checks++;
            if (lrSeen[e] != expLr[e]) begin errors++; $display("FAIL decay_lr_epoch%0d got %0d want %0d", e, lrSeen[e], expLr[e]); end
        end
        checks++; if (finalEpoch != 5)    begin errors++; $display("FAIL decay_epoch got %0d want 5", finalEpoch); end
        checks++; if (finalLR != lr_model(8, 5)) begin errors++; $display("FAIL decay_final_lr got %0d want %0d", finalLR, lr_model(8, 5)); end
    endtask

    task automatic test_epochs_zero();
        run_scenario(1'b1, 0, 5, 1'b0, 0);
        checks++; if (doneCycle != 1)     begin errors++; $display("FAIL zero_done_cycle got %0d want 1", doneCycle); end
        checks++; if (nXfer != 0 || nUp != 0) begin errors++; $display("FAIL zero_activity got %0d/%0d want 0/0", nXfer, nUp); end
        checks++; if (finalEpoch != 0 || finalLR != 5) begin errors++; $display("FAIL zero_status epoch=%0d lr=%0d want 0 5", finalEpoch, finalLR); end
        checks++; if (startLeak)          begin errors++; $display("FAIL zero_start_transfer got 1 want 0"); end
    endtask

    task automatic test_random();
        logic mode;
        int ep, lr0, stall, bad;
        for (int r = 0; r < 4; r++) begin
            mode  = 1'($urandom_range(0, 1));
            ep    = $urandom_range(1, 3);
            lr0   = $urandom_range(0, 15);
            stall = $urandom_range(0, 3);
            run_scenario(mode, ep, lr0, 1'b1, stall);
            bad = passErrs + lrErrs + epochErrs + upBatchErrs + upDropErrs + modeErrs;
            checks++; if (timedOut)       begin errors++; $display("FAIL rand%0d_timeout got 1 want 0", r); end
            checks++; if (nXfer != ep * BATCH * NBATCH) begin errors++; $display("FAIL rand%0d_xfers got %0d want %0d", r, nXfer, ep * BATCH * NBATCH); end
            checks++; if (nUp != (mode ? ep * NBATCH : 0)) begin errors++; $display("FAIL rand%0d_updates got %0d want %0d", r, nUp, mode ? ep * NBATCH : 0); end
            checks++; if (finalEpoch != ep || finalLR != lr_model(lr0, ep)) begin errors++; $display("FAIL rand%0d_final epoch=%0d lr=%0d want %0d %0d", r, finalEpoch, finalLR, ep, lr_model(lr0, ep)); end
            checks++; if (bad != 0)       begin errors++; $display("FAIL rand%0d_protocol got %0d bad want 0", r, bad); end
        end
    endtask

    task automatic test_reset_midrun();
        int n, budget;
        bit sawDone;
        n = 0; budget = 0; sawDone = 0;
        @(posedge iCLK); #1;
        iStart = 1'b1; iTrain = 1'b1; iEpochs = 8'd2; iLR0 = 4'd6;
        iValid_AS = 1'b1; iReady_BS = 1'b1; iReady_UP = 1'b0;
        @(posedge iCLK); #1;
        iStart = 1'b0;
        while (n < 13 && budget < 200) begin
            @(negedge iCLK);
            budget++;
            if (iValid_AS && oReady_AS) n++;
            if (oValid_UP) begin @(posedge iCLK); #1; iReady_UP = 1'b1; @(negedge iCLK); @(posedge iCLK); #1; iReady_UP = 1'b0; end
        end
        checks++; if (n != 13) begin errors++; $display("FAIL midrun_transfers got %0d want 13", n); end
        @(posedge iCLK); #2;
        iRST = 1'b1;
        #1;
        checks++; if ({oMode, oLR, oEpoch, oBusy, oDone, oValid_UP, oValid_BS, oReady_AS} !== '0) begin
            errors++; $display("FAIL midrun_reset_outputs mode=%0b lr=%0d epoch=%0d busy=%0b done=%0b vup=%0b vbs=%0b ras=%0b want all 0",
                               oMode, oLR, oEpoch, oBusy, oDone, oValid_UP, oValid_BS, oReady_AS);
        end
        repeat (2) begin @(negedge iCLK); if (oDone) sawDone = 1; end
        iRST = 1'b0;
        repeat (3) begin @(negedge iCLK); if (oDone || oBusy) sawDone = 1; end
        checks++; if (sawDone) begin errors++; $display("FAIL midrun_no_done got activity want none"); end
        iValid_AS = 1'b0;
        $display("reset mid-run after %0d transfers: outputs checked", n);
    endtask

    initial begin
        test_reset();
        test_train_basic();
        test_inference();
        test_update_stall();
        test_lr_decay();
        test_epochs_zero();
        test_reset_midrun();
        test_random();
        test_train_basic();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/train_scheduler.md
TRAIN_SCHEDULER -- requirements
Module: train_scheduler

Interface
REQ-001 The block SHALL have parameter WD, default 4, meaning the learning-rate width in bits.
REQ-002 The block SHALL have parameter BATCH, default 8, meaning the samples per batch (at least 1).
REQ-003 The block SHALL have parameter NBATCH, default 4, meaning the batches per epoch (at least 1).
REQ-004 The block SHALL have parameter WE, default 8, meaning the epoch counter width.
REQ-005 The block SHALL have parameter LR_MIN, default 1, meaning the learning-rate floor.
REQ-006 The block SHALL have port iCLK, input, 1 bit: the single clock; all state is updated on its rising edge.
REQ-007 The block SHALL have port iRST, input, 1 bit: asynchronous, active-high reset.
REQ-008 The block SHALL have port iStart, input, 1 bit: start pulse, sampled only in IDLE.
REQ-009 The block SHALL have port iTrain, input, 1 bit: 1 = training run, 0 = inference run; latched at start.
REQ-010 The block SHALL have port iEpochs, input, WE bits: number of epochs to run; latched at start.
REQ-011 The block SHALL have port iLR0, input, WD bits: initial learning rate; latched at start.
REQ-012 The block SHALL have ports iValid_AS (input, 1) and oReady_AS (output, 1): sample-token handshake from the upstream source.
REQ-013 The block SHALL have ports oValid_BS (output, 1) and iReady_BS (input, 1): sample-token handshake to the bias/weight datapath.
REQ-014 The block SHALL have ports oValid_UP (output, 1) and iReady_UP (input, 1): weight-update request handshake to the datapath.
REQ-015 The block SHALL have port oMode, output, 1 bit: mode driven to the datapath (latched iTrain).
REQ-016 The block SHALL have port oLR, output, WD bits: current learning rate to the datapath.
REQ-017 The block SHALL have port oEpoch, output, WE bits: number of completed epochs.
REQ-018 The block SHALL have ports oBusy (output, 1) and oDone (output, 1): busy while not IDLE; single-cycle completion pulse.

Function
REQ-019 The FSM SHALL have states IDLE, RUN, UPDATE and DONE.
REQ-020 In IDLE with iStart=1, the block SHALL latch iTrain, iEpochs and iLR0, clear all counters, and enter RUN next cycle, or DONE next cycle if iEpochs=0.
REQ-021 In RUN, the block SHALL drive oValid_BS=iValid_AS and oReady_AS=iReady_BS combinationally, with zero latency; in all other states both SHALL be 0.
REQ-022 A transfer is iValid_AS&oReady_AS; each transfer SHALL increment the sample counter, which wraps at BATCH-1 to 0.
REQ-023 On the transfer that completes a batch, the block SHALL enter UPDATE next cycle if oMode=1; if oMode=0 it SHALL stay in RUN and only advance the batch counter.
REQ-024 In UPDATE, oValid_UP SHALL be held at 1 until iReady_UP=1, and SHALL not drop while iReady_UP=0; after the accepting cycle the block SHALL return to RUN.
REQ-025 When a batch completes, the batch counter SHALL increment, wrapping at NBATCH-1 to 0; the wrap ends an epoch and oEpoch SHALL increment.
REQ-026 The batch and epoch counters SHALL advance on the UPDATE acceptance cycle in training, and on the batch-completing transfer in inference.
REQ-027 When oEpoch reaches the latched iEpochs, the block SHALL enter DONE instead of RUN.
REQ-028 DONE SHALL last exactly one cycle with oDone=1, then return to IDLE; oEpoch and oLR SHALL hold until the next start.
REQ-029 iStart SHALL be ignored outside IDLE, and latched inputs SHALL not change mid-run.
REQ-030 If iStart and iValid_AS are both high in IDLE, no transfer SHALL occur in that cycle.

Reset
REQ-031 While iRST=1, the block SHALL asynchronously set state=IDLE and clear all counters.
REQ-032 Reset values SHALL be: oMode=0, oLR=0, oEpoch=0, oBusy=0, oDone=0, oValid_UP=0, oValid_BS=0, oReady_AS=0.
REQ-033 A reset during RUN or UPDATE SHALL abandon the run, with no oDone pulse.

Configuration
REQ-034 With macro LR_DECAY_EN defined, oLR SHALL be right-shifted by 1 at each epoch end, never below LR_MIN, and an oLR already below LR_MIN SHALL be held.
REQ-035 Without LR_DECAY_EN, oLR SHALL stay at the latched iLR0 for the whole run.

Verification
REQ-036 Defaults, train, iEpochs=1, iLR0=8, iReady_BS=iReady_UP=1, continuous valid -> 4 oValid_UP requests (one per 8 transfers), oEpoch=1, one oDone pulse, 32 transfers total.
REQ-037 Inference, iEpochs=2 -> oValid_UP never asserts, 64 transfers, then oDone.
REQ-038 iReady_UP held 0 for 5 cycles in UPDATE -> oValid_UP stays 1, oReady_AS=0 throughout, and the sample counter does not change.
REQ-039 LR_DECAY_EN defined, iLR0=8, iEpochs=5 -> oLR sequence 8,4,2,1,1; without the macro, oLR stays 8.
REQ-040 iEpochs=0 -> DONE on the cycle after start, with no transfers.
REQ-041 iRST asserted mid-RUN after 13 transfers -> all outputs are at reset values immediately, with no oDone.
